// File: rtl/card_fifo_p.sv
// card_fifo_p: shift-register FIFO with a flat view of every slot in age order and sticky error flags.
// Slot 0 is always the head, and unused slots are kept at zero, so the flat view needs no masking.
module card_fifo_p #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 11,
  parameter int SAVE_EDGE = 1
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         save,
  input  logic                         pop,
  input  logic                         clear,
  input  logic [DATA_W-1:0]            data_in,
  output logic [DATA_W-1:0]            data_out,
  output logic [DEPTH*DATA_W-1:0]      data_flat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic                         overflow_o,
  output logic                         underflow_o
);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] full_v = CW'(DEPTH);
  logic [DEPTH-1:0][DATA_W-1:0] mem, mem_n;
  logic [CW-1:0] count, count_n, wpos;
  logic save_q, push_req, do_push, do_pop, ovf, unf, ovf_n, unf_n;
  always_comb begin
    push_req = (SAVE_EDGE != 0) ? (save & ~save_q) : save;
    do_pop   = pop & (count != '0);
    do_push  = push_req & ((count != full_v) | pop);
    wpos     = do_pop ? count - CW'(1) : count;
    count_n  = clear ? '0 : count + CW'(do_push) - CW'(do_pop);
    ovf_n    = ~clear & (ovf | (push_req & (count == full_v) & ~pop));
    unf_n    = ~clear & (unf | (pop & (count == '0)));
    mem_n    = do_pop ? mem >> DATA_W : mem;
    for (int i = 0; i < DEPTH; i++)
      if (do_push && wpos == CW'(i)) mem_n[i] = data_in;
    if (clear) mem_n = '0;
  end
  // save_q tracks save even across clear so a held save never re-fires
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem    <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      save_q <= 1'b0;
    end else begin
      mem    <= mem_n;
      count  <= count_n;
      ovf    <= ovf_n;
      unf    <= unf_n;
      save_q <= save;
    end
  end
  assign data_out    = mem[0];
  assign data_flat_o = mem;
  assign count_o     = count;
  assign full_o      = count == full_v;
  assign empty_o     = count == '0;
  assign overflow_o  = ovf;
  assign underflow_o = unf;
endmodule

// File: tb/tb_card_fifo_p.sv
// tb_card_fifo_p: directed scenarios against a queue scoreboard for a default and a small level-mode FIFO.
module tb_card_fifo_p;
  logic clk = 1'b0;
  logic rst_n, save, pop, clear;
  logic [7:0] din, dout;
  logic [87:0] flat;
  logic [3:0] cnt;
  logic full, empty, ovf, unf;
  logic rst2_n, save2;
  logic [3:0] din2, dout2;
  logic [15:0] flat2;
  logic [2:0] cnt2;
  logic full2, empty2, ovf2, unf2;
  logic [7:0] q[$];
  logic [7:0] head;
  int n = 0;
  int errs = 0;

  card_fifo_p u_dut (
    .clk_i(clk), .rst_i(rst_n), .save(save), .pop(pop), .clear(clear), .data_in(din),
    .data_out(dout), .data_flat_o(flat), .count_o(cnt), .full_o(full), .empty_o(empty),
    .overflow_o(ovf), .underflow_o(unf));

  card_fifo_p #(.DATA_W(4), .DEPTH(4), .SAVE_EDGE(0)) u_lvl (
    .clk_i(clk), .rst_i(rst2_n), .save(save2), .pop(1'b0), .clear(1'b0), .data_in(din2),
    .data_out(dout2), .data_flat_o(flat2), .count_o(cnt2), .full_o(full2), .empty_o(empty2),
    .overflow_o(ovf2), .underflow_o(unf2));

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] mflat();
    logic [127:0] r = '0;
    foreach (q[i]) r[i*8 +: 8] = q[i];
    return r;
  endfunction

  task automatic push_pulse(input logic [7:0] v);
    din = v; save = 1'b1;
    step();
    save = 1'b0;
    q.push_back(v);
    step();
  endtask

  initial begin
    rst_n = 1'b0; save = 1'b0; pop = 1'b0; clear = 1'b0; din = '0;
    rst2_n = 1'b0; save2 = 1'b0; din2 = '0;
    #3;
    chk("rst_count", cnt, 0);
    chk("rst_empty", empty, 1);
    chk("rst_flat", flat, 0);
    chk("rst_flags", {ovf, unf}, 0);
    rst_n = 1'b1;
    // held save in edge mode yields a single push
    din = 8'h0A; save = 1'b1;
    q.push_back(8'h0A);
    repeat (10) step();
    chk("edge_count", cnt, 1);
    chk("edge_dout", dout, 8'h0A);
    chk("edge_slot1", flat[15:8], 0);
    save = 1'b0; pop = 1'b1;
    head = q.pop_front();
    chk("pop_head", dout, head);
    step();
    pop = 1'b0;
    chk("pop_empty", empty, 1);
    for (int v = 1; v <= 11; v++) push_pulse(8'(v));
    chk("fill_full", full, 1);
    chk("fill_flat", flat, mflat());
    din = 8'hFF; save = 1'b1;
    step();
    save = 1'b0;
    step();
    chk("ovf_flag", ovf, 1);
    chk("ovf_count", cnt, 11);
    chk("ovf_flat", flat, mflat());
    din = 8'h20; save = 1'b1; pop = 1'b1;
    head = q.pop_front();
    chk("full_pp_head", dout, head);
    q.push_back(8'h20);
    step();
    save = 1'b0; pop = 1'b0;
    chk("full_pp_count", cnt, 11);
    chk("full_pp_slot0", flat[7:0], 8'h02);
    chk("full_pp_slot10", flat[87:80], 8'h20);
    chk("full_pp_flat", flat, mflat());
    step();
    chk("ovf_sticky", ovf, 1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    q.delete();
    chk("clr_count", cnt, 0);
    chk("clr_ovf", ovf, 0);
    pop = 1'b1;
    step();
    chk("unf_flag", unf, 1);
    chk("unf_count", cnt, 0);
    din = 8'h05; save = 1'b1;
    q.push_back(8'h05);
    step();
    save = 1'b0; pop = 1'b0;
    chk("unf_push_count", cnt, 1);
    chk("unf_push_dout", dout, 8'h05);
    chk("unf_sticky", unf, 1);
    step();
    for (int v = 6; v <= 9; v++) push_pulse(8'(v));
    chk("five_count", cnt, 5);
    chk("five_flat", flat, mflat());
    din = 8'h77; clear = 1'b1; save = 1'b1; pop = 1'b1;
    step();
    clear = 1'b0; pop = 1'b0;
    q.delete();
    chk("clrpri_count", cnt, 0);
    chk("clrpri_flat", flat, 0);
    chk("clrpri_flags", {ovf, unf}, 0);
    step();
    chk("clr_hist_count", cnt, 0);
    save = 1'b0;
    step();
    push_pulse(8'h31);
    push_pulse(8'h32);
    chk("pre_rst_count", cnt, 2);
    // asynchronous reset mid-cycle with save held across release
    #2 rst_n = 1'b0; save = 1'b1; din = 8'h44;
    #1;
    chk("arst_count", cnt, 0);
    chk("arst_flat", flat, 0);
    chk("arst_empty", empty, 1);
    rst_n = 1'b1;
    q.delete();
    q.push_back(8'h44);
    step();
    save = 1'b0;
    chk("rel_count", cnt, 1);
    chk("rel_dout", dout, q[0]);
    rst2_n = 1'b1; save2 = 1'b1; din2 = 4'h3;
    for (int k = 1; k <= 6; k++) begin
      step();
      chk($sformatf("lvl_count%0d", k), cnt2, (k < 4) ? k : 4);
      if (k == 4) chk("lvl_full", full2, 1);
    end
    chk("lvl_ovf", ovf2, 1);
    chk("lvl_flat", flat2, 16'h3333);
    #2 rst2_n = 1'b0;
    #1;
    chk("lvl_arst_count", cnt2, 0);
    chk("lvl_arst_flat", flat2, 0);
    chk("lvl_arst_flags", {ovf2, unf2, empty2}, 3'b001);
    $display("End of test - %0d assertions evaluated, %0d failures", n, errs);
    $finish;
  end
endmodule
